// File: rtl/seq_digit_adder.sv
// seq_digit_adder: multi-cycle digit-serial adder with start/done handshake.
// Optional macro SEQ_DIGIT_ADDER_SUB_EN adds a sub input for a - b.
module seq_digit_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef SEQ_DIGIT_ADDER_SUB_EN
    input  logic             sub,
`endif
    input  logic             ci,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [WIDTH-1:0]       a_q, a_d, b_q, b_d, acc_q, acc_d, sum_q, sum_d;
    logic                   c_q, c_d, co_q, co_d, ovf_q, ovf_d;
    logic [DIGIT:0]         dsum;
    logic [WIDTH+DIGIT-1:0] acc_sh;
    logic                   last, b_inv, c_init;

`ifdef SEQ_DIGIT_ADDER_SUB_EN
    assign b_inv  = sub;
    assign c_init = sub | ci;
`else
    assign b_inv  = 1'b0;
    assign c_init = ci;
`endif

    // One digit of the add; the new digit enters the accumulator from the top.
    assign dsum   = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + (DIGIT+1)'(c_q);
    assign acc_sh = {dsum[DIGIT-1:0], acc_q};
    assign last   = cnt_q == CW'(N - 1);

    assign busy = state_q != IDLE;
    assign done = state_q == DONE;
    assign sum  = sum_q;
    assign co   = co_q;
    assign ovf  = ovf_q;

    // Next-state and datapath updates; results only move on the final digit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        co_d    = co_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: if (start) begin
                a_d     = a;
                b_d     = b_inv ? ~b : b;
                c_d     = c_init;
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                acc_d = acc_sh[WIDTH+DIGIT-1:DIGIT];
                c_d   = dsum[DIGIT];
                a_d   = a_q >> DIGIT;
                b_d   = b_q >> DIGIT;
                cnt_d = cnt_q + 1'b1;
                if (last) begin
                    sum_d   = acc_d;
                    co_d    = dsum[DIGIT];
                    // carry into the MSB is recovered from the MSB's own sum bit
                    ovf_d   = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ dsum[DIGIT-1] ^ dsum[DIGIT];
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            acc_q   <= '0;
            sum_q   <= '0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: doc/seq_digit_adder.md
Name: seq_digit_adder

Overview:
- Parametrised multi-cycle adder. Adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock, least-significant digit first.
- Successor to the fixed 2-bit combinational adder cell. Trades latency for a small carry chain on wide datapaths.
- Start/done handshake so a controller FSM can issue operations back to back.
- Result, carry-out and signed overflow are held stable until the next operation completes.

Parameters:
- WIDTH, 8, operand and sum width in bits. Must be a multiple of DIGIT and at least 2.
- DIGIT, 2, bits added per cycle. 1 gives a pure bit-serial adder; DIGIT = WIDTH gives a single-cycle add.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request. Sampled only in IDLE.
- ci  in  1  carry-in. Latched with start.
- a  in  WIDTH  operand A. Latched with start.
- b  in  WIDTH  operand B. Latched with start.
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle completion pulse
- sum  out  WIDTH  registered result
- co  out  1  carry out of bit WIDTH-1
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Reset: asynchronous on rst_n low, regardless of state or clock.
  - State goes to IDLE.
  - busy, done, sum, co and ovf all 0. Digit counter and internal operand/carry registers all 0.
  - Reset during RUN abandons the operation. No done is produced.
- Let N = WIDTH/DIGIT.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On an edge with start=1: latch a, b and ci into shift registers. Clear the digit counter. Go to RUN. busy=1 from that edge.
  - start=0: stay in IDLE.
- RUN: each edge adds the low DIGIT bits of the A and B shift registers plus the carry register.
  - The DIGIT-bit result is shifted into the top of the internal sum register. The carry register takes the digit carry-out.
  - The operand registers shift right by DIGIT. The counter increments.
  - On the edge processing digit N-1:
    - load the output sum from the completed internal value;
    - load co with the final carry;
    - load ovf from the carry into bit WIDTH-1 XOR co;
    - go to DONE.
- DONE:
  - done=1 for exactly this one cycle. busy stays 1.
  - Next edge returns to IDLE with done=0 and busy=0.
- Latency: start sampled at edge k gives results and done=1 after edge k+N. The next start can be accepted at edge k+N+2. Throughput is one operation per N+2 cycles.
- start while busy=1 is ignored. It is not queued. Operands and carry-in presented then are not captured.
- sum, co and ovf change only at the completion edge. They hold between operations and across IDLE.
- Arithmetic is modulo 2^WIDTH. co is the unsigned carry; ovf is two's-complement overflow. Both are valid for every WIDTH/DIGIT combination.
- DIGIT = WIDTH: N=1. Behaviour still follows the IDLE -> RUN (1 cycle) -> DONE sequence.

Optional Feature:
- Macro: SEQ_DIGIT_ADDER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), latched with start.
  - sub=1 computes a - b as a + ~b + 1. The B register is loaded inverted and the carry register is forced to 1; ci is ignored.
  - co=1 means no borrow (a >= b unsigned). ovf is signed subtraction overflow.
  - sub=0 behaves exactly as the base block.
- Undefined: no sub port. Addition only. The logic is identical to the base block.

Test Plan:
- WIDTH=8, DIGIT=2: a=8'h35, b=8'h4A, ci=0, start pulsed at edge k -> busy=1 from edge k, done=1 only after edge k+4, sum=8'h7F, co=0, ovf=0. busy=0 after edge k+5.
- a=8'hFF, b=8'h01, ci=0 -> sum=8'h00, co=1, ovf=0. Then a=8'h7F, b=8'h00, ci=1 -> sum=8'h80, co=0, ovf=1.
- Re-assert start with a=8'h01, b=8'h01 during RUN of a=8'h10, b=8'h20 -> a single done, sum=8'h30. No second done follows. sum holds 8'h30 through 10 idle cycles.
- rst_n pulsed low mid-RUN, asynchronously between edges -> busy, done, sum, co, ovf read 0 immediately. No done after release. A new start then completes normally.
- Rebuild WIDTH=4, DIGIT=1: a=4'h9, b=4'h9, ci=1 -> done after 4 cycles, sum=4'h3, co=1, ovf=1. Rebuild WIDTH=8, DIGIT=8: same timing with done after 1 RUN cycle.
- With SEQ_DIGIT_ADDER_SUB_EN, sub=1: a=8'h10, b=8'h20 -> sum=8'hF0, co=0, ovf=0. Then a=8'h80, b=8'h01 -> sum=8'h7F, co=1, ovf=1.
